// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - ID-stage hazard detection with stall/flush selects and stall counter
module hazard_stall_unit #(
    parameter int LOAD_BR_STALL = 2,
    parameter int CNT_W         = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             ID_IsBranch,
    input  logic             ID_BranchTaken,
    input  logic             EX_MemRead,
    input  logic             EX_RegWrite,
    input  logic [4:0]       EX_WriteReg,
    input  logic             MEM_MemRead,
    input  logic [4:0]       MEM_WriteReg,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             CtrlBubbleSel,
    output logic             IFFlush,
    output logic [CNT_W-1:0] StallCount
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [2:0] BR_NEED = 3'(LOAD_BR_STALL);

    state_t     state;
    state_t     state_next;
    logic [2:0] cnt;
    logic [2:0] cnt_next;
    logic       ex_match;
    logic       mem_match;
    logic       lu;
    logic       balu;
    logic       bmem;
    logic [2:0] need;

    // A destination register conflicts with the ID instruction only if it is a real source; $0 never does
    assign ex_match  = (EX_WriteReg != 5'd0) &&
                       ((EX_WriteReg == ID_Rs) || (ID_UsesRt && (EX_WriteReg == ID_Rt)));
    assign mem_match = (MEM_WriteReg != 5'd0) &&
                       ((MEM_WriteReg == ID_Rs) || (ID_UsesRt && (MEM_WriteReg == ID_Rt)));

    assign lu   = EX_MemRead & ex_match;
    assign balu = ID_IsBranch & EX_RegWrite & ~EX_MemRead & ex_match;
    assign bmem = ID_IsBranch & MEM_MemRead & mem_match;

    // Required stall length is the largest demand among the active hazard terms
    always_comb begin
        need = 3'd0;
        if (balu || bmem) begin
            need = 3'd1;
        end
        if (lu) begin
            need = ID_IsBranch ? BR_NEED : 3'd1;
        end
    end

    // State and down-counter registers; reset drops any stall in progress
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state and Mealy outputs; stall wins over a taken-branch flush
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        PCWrite       = 1'b1;
        IFIDWrite     = 1'b1;
        CtrlBubbleSel = 1'b0;
        IFFlush       = 1'b0;
        if (!Reset) begin
            case (state)
                RUN: begin
                    if (need != 3'd0) begin
                        PCWrite       = 1'b0;
                        IFIDWrite     = 1'b0;
                        CtrlBubbleSel = 1'b1;
                        if (need > 3'd1) begin
                            state_next = STALL;
                            cnt_next   = need - 3'd1;
                        end
                    end else begin
                        IFFlush = ID_BranchTaken;
                    end
                end
                STALL: begin
                    PCWrite       = 1'b0;
                    IFIDWrite     = 1'b0;
                    CtrlBubbleSel = 1'b1;
                    cnt_next      = cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state_next = RUN;
                    end
                end
                default: begin
                    state_next = RUN;
                    cnt_next   = 3'd0;
                end
            endcase
        end
    end

    // Saturating count of cycles in which a bubble was inserted
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            StallCount <= '0;
        end else if (CtrlBubbleSel && (StallCount != {CNT_W{1'b1}})) begin
            StallCount <= StallCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - self-checking bench for hazard_stall_unit
module tb_hazard_stall_unit;

    localparam int LBS   = 2;
    localparam int CW    = 16;
    localparam int SATV  = (1 << CW) - 1;

    logic          Clk;
    logic          Reset;
    logic [4:0]    ID_Rs;
    logic [4:0]    ID_Rt;
    logic          ID_UsesRt;
    logic          ID_IsBranch;
    logic          ID_BranchTaken;
    logic          EX_MemRead;
    logic          EX_RegWrite;
    logic [4:0]    EX_WriteReg;
    logic          MEM_MemRead;
    logic [4:0]    MEM_WriteReg;
    logic          PCWrite;
    logic          IFIDWrite;
    logic          CtrlBubbleSel;
    logic          IFFlush;
    logic [CW-1:0] StallCount;

    int checks   = 0;
    int failures = 0;
    int hold_left = 0;
    int exp_count = 0;

    hazard_stall_unit #(.LOAD_BR_STALL(LBS), .CNT_W(CW)) dut (
        .Clk(Clk), .Reset(Reset),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .ID_IsBranch(ID_IsBranch), .ID_BranchTaken(ID_BranchTaken),
        .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_WriteReg(EX_WriteReg),
        .MEM_MemRead(MEM_MemRead), .MEM_WriteReg(MEM_WriteReg),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .CtrlBubbleSel(CtrlBubbleSel),
        .IFFlush(IFFlush), .StallCount(StallCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit reads(input logic [4:0] r);
        return (r != 0) && (r == ID_Rs || (ID_UsesRt && r == ID_Rt));
    endfunction

    // Stall cycles demanded by the current ID/EX/MEM contents
    function automatic int demand();
        int d = 0;
        if (ID_IsBranch && MEM_MemRead && reads(MEM_WriteReg)) d = 1;
        if (ID_IsBranch && EX_RegWrite && !EX_MemRead && reads(EX_WriteReg)) d = 1;
        if (EX_MemRead && reads(EX_WriteReg)) d = ID_IsBranch ? LBS : 1;
        return d;
    endfunction

    function automatic bit stalled_now();
        if (Reset) return 1'b0;
        if (hold_left > 0) return 1'b1;
        return demand() > 0;
    endfunction

    // Model: remaining committed stall cycles and the expected counter
    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hold_left = 0;
            exp_count = 0;
        end else begin
            if (stalled_now()) exp_count = (exp_count < SATV) ? exp_count + 1 : SATV;
            if (hold_left > 0) hold_left = hold_left - 1;
            else if (demand() > 0) hold_left = demand() - 1;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge Clk) begin
        bit s;
        s = stalled_now();
        chk("m_pcwrite", PCWrite, !s);
        chk("m_ifidwrite", IFIDWrite, !s);
        chk("m_bubble", CtrlBubbleSel, s);
        chk("m_ifflush", IFFlush, !Reset && !s && ID_BranchTaken);
        chk("m_count", StallCount, exp_count);
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        ID_Rs = 0; ID_Rt = 0; ID_UsesRt = 0; ID_IsBranch = 0; ID_BranchTaken = 0;
        EX_MemRead = 0; EX_RegWrite = 0; EX_WriteReg = 0;
        MEM_MemRead = 0; MEM_WriteReg = 0;
    endtask

    task automatic lit(input string name, input bit bub, input bit fl);
        #2;
        chk({name, "_bubble"}, CtrlBubbleSel, bub);
        chk({name, "_pcwrite"}, PCWrite, !bub);
        chk({name, "_ifflush"}, IFFlush, fl);
    endtask

    initial begin
        Reset = 1'b1;
        idle();
        EX_MemRead = 1; EX_WriteReg = 5'd8; ID_Rs = 5'd8;
        #3;
        chk("rst_pcwrite", PCWrite, 1);
        chk("rst_ifidwrite", IFIDWrite, 1);
        chk("rst_bubble", CtrlBubbleSel, 0);
        chk("rst_count", StallCount, 0);
        idle();
        cyc();
        Reset = 1'b0;
        cyc();

        // 1: lw $t0 then dependent add
        EX_MemRead = 1; EX_RegWrite = 1; EX_WriteReg = 5'd8; ID_Rs = 5'd8;
        lit("t1_stall", 1, 0);
        cyc();
        idle(); MEM_MemRead = 1; MEM_WriteReg = 5'd8; ID_Rs = 5'd8;
        lit("t1_after", 0, 0);
        chk("t1_count", StallCount, 1);
        cyc(); idle();

        // 2: lw $t1 then beq $t1,$t2
        EX_MemRead = 1; EX_RegWrite = 1; EX_WriteReg = 5'd9;
        ID_Rs = 5'd9; ID_Rt = 5'd10; ID_UsesRt = 1; ID_IsBranch = 1;
        lit("t2_c1", 1, 0);
        cyc();
        EX_MemRead = 0; EX_RegWrite = 0; EX_WriteReg = 0;
        MEM_MemRead = 1; MEM_WriteReg = 5'd9; ID_BranchTaken = 1;
        lit("t2_c2", 1, 0);
        cyc();
        MEM_MemRead = 0; MEM_WriteReg = 0;
        lit("t2_c3", 0, 1);
        chk("t2_count", StallCount, 3);
        cyc(); idle();

        // 3: ALU result feeding a branch, and feeding a plain ALU op
        EX_RegWrite = 1; EX_WriteReg = 5'd11; ID_Rs = 5'd11; ID_IsBranch = 1;
        lit("t3_br", 1, 0);
        cyc();
        ID_IsBranch = 0;
        lit("t3_alu", 0, 0);
        chk("t3_count", StallCount, 4);
        cyc(); idle();

        // 4: $0 and unused Rt never stall
        EX_MemRead = 1; EX_RegWrite = 1; EX_WriteReg = 5'd0; ID_Rs = 5'd0; ID_UsesRt = 1;
        lit("t4_r0", 0, 0);
        cyc();
        EX_WriteReg = 5'd12; ID_Rs = 5'd3; ID_Rt = 5'd12; ID_UsesRt = 0;
        lit("t4_nort", 0, 0);
        cyc();
        ID_UsesRt = 1;
        lit("t4_rt", 1, 0);
        cyc(); idle();

        // 5: taken branch flush, then flush suppressed by a stall
        ID_IsBranch = 1; ID_BranchTaken = 1; ID_Rs = 5'd4;
        lit("t5_flush", 0, 1);
        cyc();
        ID_BranchTaken = 0;
        lit("t5_noflush", 0, 0);
        cyc();
        ID_BranchTaken = 1; EX_RegWrite = 1; EX_WriteReg = 5'd4;
        lit("t5_stallwins", 1, 0);
        cyc(); idle();
        chk("t5_count", StallCount, 6);

        // 6: reset in the second cycle of a load-branch stall
        EX_MemRead = 1; EX_RegWrite = 1; EX_WriteReg = 5'd9;
        ID_Rs = 5'd9; ID_IsBranch = 1;
        lit("t6_c1", 1, 0);
        cyc();
        idle();
        #2;
        Reset = 1'b1;
        #1;
        chk("t6_rst_bubble", CtrlBubbleSel, 0);
        chk("t6_rst_pcwrite", PCWrite, 1);
        chk("t6_rst_count", StallCount, 0);
        cyc();
        Reset = 1'b0;
        lit("t6_noresid", 0, 0);
        cyc();

        // Saturation: continuous load-use stall for more than 2^CW cycles
        EX_MemRead = 1; EX_WriteReg = 5'd5; ID_Rs = 5'd5;
        for (int i = 0; i < SATV + 5; i++) cyc();
        chk("sat_count", StallCount, 16'hFFFF);
        idle();
        cyc();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
